// File: rtl/uarch_pkg.sv
// uarch_pkg: shared decode types, queue select enum and routing helper
package uarch_pkg;
  typedef struct packed {
    logic        is_valid;
    logic        is_load;
    logic        is_store;
    logic        is_muldiv;
    logic        is_branch;
    logic        is_jump;
    logic [4:0]  rd;
    logic [31:0] pc;
  } decoded_inst_t;
  typedef enum logic [1:0] {IQ_ALU, IQ_MEM, IQ_MDU} iq_sel_e;
  typedef enum logic {PAIR, HALF} disp_state_e;
  localparam int NUM_IQ = 3;
  function automatic iq_sel_e iq_route(decoded_inst_t i);
    return (i.is_load || i.is_store) ? IQ_MEM : i.is_muldiv ? IQ_MDU : IQ_ALU;
  endfunction
endpackage

// File: rtl/iq_credit_ctr.sv
// iq_credit_ctr: free-slot credit counter for one issue queue
module iq_credit_ctr #(
  parameter int DEPTH = 8,
  localparam int W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reload,
  input  logic [1:0]   enq_cnt,
  input  logic [1:0]   free,
  output logic [W-1:0] credits
);
  logic [W+1:0] nxt;
  assign nxt = {2'b0, credits} - {W'(0), enq_cnt} + {W'(0), free};
  always_ff @(posedge clk) begin
    credits <= (rst || reload) ? W'(DEPTH) : nxt[W-1:0];
    if (!rst && !reload)
      assert ({2'b0, credits} + {W'(0), free} >= {W'(0), enq_cnt} && nxt <= (W+2)'(DEPTH));
  end
endmodule

// File: rtl/dispatch_sched.sv
// dispatch_sched: in-order two-wide dispatch into ALU/MEM/MDU issue queues with credits
module dispatch_sched
  import uarch_pkg::*;
#(
  parameter int ALU_DEPTH = 8,
  parameter int MEM_DEPTH = 8,
  parameter int MDU_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_val,
  output logic                in_rdy,
  input  decoded_inst_t       in_inst0,
  input  decoded_inst_t       in_inst1,
  output logic [1:0]          alu_enq_val,
  output decoded_inst_t [1:0] alu_enq_inst,
  input  logic [1:0]          alu_free,
  output logic [1:0]          mem_enq_val,
  output decoded_inst_t [1:0] mem_enq_inst,
  input  logic [1:0]          mem_free,
  output logic [1:0]          mdu_enq_val,
  output decoded_inst_t [1:0] mdu_enq_inst,
  input  logic [1:0]          mdu_free
);
  disp_state_e state, state_n;
  iq_sel_e r0, r1;
  logic pend0, d0, d1, go, e0, e1, hold;
  decoded_inst_t p0, p1;
  logic [$clog2(ALU_DEPTH+1)-1:0] alu_credits;
  logic [$clog2(MEM_DEPTH+1)-1:0] mem_credits;
  logic [$clog2(MDU_DEPTH+1)-1:0] mdu_credits;
  logic [7:0] crd [NUM_IQ];
  logic [1:0] ev [NUM_IQ];
  logic [1:0] cnt [NUM_IQ];
  decoded_inst_t [1:0] ep [NUM_IQ];
  assign crd[IQ_ALU] = 8'(alu_credits);
  assign crd[IQ_MEM] = 8'(mem_credits);
  assign crd[IQ_MDU] = 8'(mdu_credits);
  always_comb begin
    r0 = iq_route(in_inst0);
    r1 = iq_route(in_inst1);
    pend0 = state == PAIR && in_inst0.is_valid;
    d0 = state == HALF || !in_inst0.is_valid || crd[r0] != 8'd0;
    d1 = d0 && (!in_inst1.is_valid || crd[r1] >= ((pend0 && r0 == r1) ? 8'd2 : 8'd1));
    go = in_val && !flush && !rst;
    e0 = go && pend0 && d0;
    e1 = go && in_inst1.is_valid && d1;
    in_rdy = (rst || flush) ? 1'b0 : !in_val ? 1'b1 : d1;
    state_n = (rst || flush) ? PAIR : !in_val ? state : d1 ? PAIR : d0 ? HALF : state;
  end
  for (genvar q = 0; q < NUM_IQ; q++) begin : g_q
    logic a, b;
    assign a = e0 && r0 == iq_sel_e'(q);
    assign b = e1 && r1 == iq_sel_e'(q);
    assign ev[q] = {a & b, a | b};
    assign ep[q] = {in_inst1, a ? in_inst0 : in_inst1};
    assign cnt[q] = {1'b0, a} + {1'b0, b};
  end
  assign alu_enq_val = ev[IQ_ALU];
  assign mem_enq_val = ev[IQ_MEM];
  assign mdu_enq_val = ev[IQ_MDU];
  assign alu_enq_inst = ep[IQ_ALU];
  assign mem_enq_inst = ep[IQ_MEM];
  assign mdu_enq_inst = ep[IQ_MDU];
  iq_credit_ctr #(.DEPTH(ALU_DEPTH)) u_alu (.clk(clk), .rst(rst), .reload(flush), .enq_cnt(cnt[IQ_ALU]), .free(alu_free), .credits(alu_credits));
  iq_credit_ctr #(.DEPTH(MEM_DEPTH)) u_mem (.clk(clk), .rst(rst), .reload(flush), .enq_cnt(cnt[IQ_MEM]), .free(mem_free), .credits(mem_credits));
  iq_credit_ctr #(.DEPTH(MDU_DEPTH)) u_mdu (.clk(clk), .rst(rst), .reload(flush), .enq_cnt(cnt[IQ_MDU]), .free(mdu_free), .credits(mdu_credits));
  always_ff @(posedge clk) begin
    state <= state_n;
    hold <= !rst && !flush && in_val && !in_rdy;
    p0 <= in_inst0;
    p1 <= in_inst1;
    if (!rst && !flush) begin
      if (hold) assert (in_val && in_inst0 == p0 && in_inst1 == p1);
      if (state == HALF) assert (in_val);
    end
  end
endmodule

// File: tb/tb_dispatch_sched.sv
// tb_dispatch_sched: directed scoreboard bench for dispatch_sched
module tb_dispatch_sched;
  import uarch_pkg::*;
  logic clk = 1'b0;
  logic rst, flush, in_val, in_rdy;
  decoded_inst_t in_inst0, in_inst1;
  logic [1:0] alu_enq_val, mem_enq_val, mdu_enq_val;
  decoded_inst_t [1:0] alu_enq_inst, mem_enq_inst, mdu_enq_inst;
  logic [1:0] alu_free, mem_free, mdu_free;
  int vecs = 0, miscmp = 0;
  typedef struct {
    string tag;
    logic rdy;
    logic [1:0] av, mv, dv;
    decoded_inst_t a0, a1, m0, m1, d0, d1;
  } exp_t;
  exp_t sb[$];
  decoded_inst_t ADD, ADD2, LW, SW1, SW2, MULA, MULB, BEQ, BUB, N;

  dispatch_sched dut (
    .clk(clk), .rst(rst), .flush(flush), .in_val(in_val), .in_rdy(in_rdy),
    .in_inst0(in_inst0), .in_inst1(in_inst1),
    .alu_enq_val(alu_enq_val), .alu_enq_inst(alu_enq_inst), .alu_free(alu_free),
    .mem_enq_val(mem_enq_val), .mem_enq_inst(mem_enq_inst), .mem_free(mem_free),
    .mdu_enq_val(mdu_enq_val), .mdu_enq_inst(mdu_enq_inst), .mdu_free(mdu_free)
  );

  always #5 clk = ~clk;

  function automatic decoded_inst_t mk(logic v, logic ld, logic st, logic md, logic br, logic [31:0] pc);
    decoded_inst_t i;
    i = '0;
    i.is_valid = v;
    i.is_load = ld;
    i.is_store = st;
    i.is_muldiv = md;
    i.is_branch = br;
    i.rd = pc[6:2];
    i.pc = pc;
    return i;
  endfunction

  function automatic exp_t ex(string tag, logic rdy,
                              logic [1:0] av, decoded_inst_t a0, decoded_inst_t a1,
                              logic [1:0] mv, decoded_inst_t m0, decoded_inst_t m1,
                              logic [1:0] dv, decoded_inst_t d0, decoded_inst_t d1);
    exp_t e;
    e.tag = tag; e.rdy = rdy;
    e.av = av; e.a0 = a0; e.a1 = a1;
    e.mv = mv; e.m0 = m0; e.m1 = m1;
    e.dv = dv; e.d0 = d0; e.d1 = d1;
    return e;
  endfunction

  task automatic cmp(string tag, logic [63:0] o, logic [63:0] e);
    vecs++;
    assert (o === e) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check;
    exp_t e;
    if (sb.size() == 0) begin
      cmp("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".rdy"}, 64'(in_rdy), 64'(e.rdy));
    cmp({e.tag, ".alu_val"}, 64'(alu_enq_val), 64'(e.av));
    cmp({e.tag, ".mem_val"}, 64'(mem_enq_val), 64'(e.mv));
    cmp({e.tag, ".mdu_val"}, 64'(mdu_enq_val), 64'(e.dv));
    if (e.av[0]) cmp({e.tag, ".alu0"}, 64'(alu_enq_inst[0]), 64'(e.a0));
    if (e.av[1]) cmp({e.tag, ".alu1"}, 64'(alu_enq_inst[1]), 64'(e.a1));
    if (e.mv[0]) cmp({e.tag, ".mem0"}, 64'(mem_enq_inst[0]), 64'(e.m0));
    if (e.mv[1]) cmp({e.tag, ".mem1"}, 64'(mem_enq_inst[1]), 64'(e.m1));
    if (e.dv[0]) cmp({e.tag, ".mdu0"}, 64'(mdu_enq_inst[0]), 64'(e.d0));
    if (e.dv[1]) cmp({e.tag, ".mdu1"}, 64'(mdu_enq_inst[1]), 64'(e.d1));
  endtask

  task automatic step(input exp_t e);
    sb.push_back(e);
    #4;
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic v, decoded_inst_t i0, decoded_inst_t i1, logic [1:0] af, logic [1:0] mf, logic [1:0] df, logic fl);
    in_val = v; in_inst0 = i0; in_inst1 = i1;
    alu_free = af; mem_free = mf; mdu_free = df; flush = fl;
  endtask

  task automatic crd(string tag, int a, int m, int d);
    cmp({tag, ".alu_crd"}, 64'(dut.alu_credits), 64'(a));
    cmp({tag, ".mem_crd"}, 64'(dut.mem_credits), 64'(m));
    cmp({tag, ".mdu_crd"}, 64'(dut.mdu_credits), 64'(d));
  endtask

  initial begin
    ADD  = mk(1, 0, 0, 0, 0, 32'h100);
    LW   = mk(1, 1, 0, 0, 0, 32'h104);
    MULA = mk(1, 0, 0, 1, 0, 32'h108);
    MULB = mk(1, 0, 0, 1, 0, 32'h10c);
    SW1  = mk(1, 0, 1, 0, 0, 32'h110);
    SW2  = mk(1, 0, 1, 0, 0, 32'h114);
    BEQ  = mk(1, 0, 0, 0, 1, 32'h118);
    BUB  = mk(0, 0, 0, 0, 0, 32'h11c);
    ADD2 = mk(1, 0, 0, 0, 0, 32'h120);
    N = '0;
    rst = 1'b1;
    drv(0, N, N, 0, 0, 0, 0);
    @(posedge clk); #1;
    drv(1, ADD, LW, 0, 0, 0, 0);
    step(ex("rst", 0, 0, N, N, 0, N, N, 0, N, N));
    rst = 1'b0;
    drv(0, N, N, 0, 0, 0, 0);
    crd("reset", 8, 8, 4);
    drv(1, ADD, LW, 0, 0, 0, 0);
    step(ex("t1", 1, 2'b01, ADD, N, 2'b01, LW, N, 0, N, N));
    crd("t1", 7, 7, 4);
    drv(1, MULA, MULB, 0, 0, 0, 0);
    step(ex("mm", 1, 0, N, N, 0, N, N, 2'b11, MULA, MULB));
    drv(1, MULA, ADD, 0, 0, 0, 0);
    step(ex("ma", 1, 2'b01, ADD, N, 0, N, N, 2'b01, MULA, N));
    crd("ma", 6, 7, 1);
    drv(1, MULA, MULB, 0, 0, 1, 0);
    step(ex("t2a", 0, 0, N, N, 0, N, N, 2'b01, MULA, N));
    drv(1, MULA, MULB, 0, 0, 0, 0);
    step(ex("t2b", 1, 0, N, N, 0, N, N, 2'b01, MULB, N));
    crd("t2", 6, 7, 0);
    drv(0, MULA, MULB, 0, 0, 2, 0);
    step(ex("idle", 1, 0, N, N, 0, N, N, 0, N, N));
    step(ex("idle2", 1, 0, N, N, 0, N, N, 0, N, N));
    crd("mdu_back", 6, 7, 4);
    drv(1, LW, SW1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(ex("drain_m", 1, 0, N, N, 2'b11, LW, SW1, 0, N, N));
    drv(1, LW, BUB, 0, 0, 0, 0);
    step(ex("lw_bub", 1, 0, N, N, 2'b01, LW, N, 0, N, N));
    crd("mem0", 6, 0, 4);
    drv(1, SW1, SW2, 0, 2, 0, 0);
    step(ex("t3a", 0, 0, N, N, 0, N, N, 0, N, N));
    drv(1, SW1, SW2, 0, 0, 0, 0);
    step(ex("t3b", 1, 0, N, N, 2'b11, SW1, SW2, 0, N, N));
    crd("t3", 6, 0, 4);
    drv(0, N, N, 1, 2, 0, 0);
    step(ex("rest1", 1, 0, N, N, 0, N, N, 0, N, N));
    step(ex("rest2", 1, 0, N, N, 0, N, N, 0, N, N));
    drv(0, N, N, 0, 2, 0, 0);
    step(ex("rest3", 1, 0, N, N, 0, N, N, 0, N, N));
    step(ex("rest4", 1, 0, N, N, 0, N, N, 0, N, N));
    crd("rest", 8, 8, 4);
    drv(1, BUB, BEQ, 0, 0, 0, 0);
    step(ex("t4", 1, 2'b01, BEQ, N, 0, N, N, 0, N, N));
    crd("t4", 7, 8, 4);
    drv(1, LW, SW1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(ex("drain_m2", 1, 0, N, N, 2'b11, LW, SW1, 0, N, N));
    crd("mem0b", 7, 0, 4);
    drv(1, ADD, LW, 0, 0, 0, 0);
    step(ex("t5a", 0, 2'b01, ADD, N, 0, N, N, 0, N, N));
    drv(1, ADD, LW, 0, 1, 0, 1);
    step(ex("t5f", 0, 0, N, N, 0, N, N, 0, N, N));
    drv(1, ADD, LW, 0, 0, 0, 0);
    crd("t5", 8, 8, 4);
    step(ex("t5p", 1, 2'b01, ADD, N, 2'b01, LW, N, 0, N, N));
    crd("t5p", 7, 7, 4);
    drv(1, ADD, ADD2, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(ex("drain_a", 1, 2'b11, ADD, ADD2, 0, N, N, 0, N, N));
    drv(1, ADD, BUB, 0, 0, 0, 0);
    step(ex("add_bub", 1, 2'b01, ADD, N, 0, N, N, 0, N, N));
    crd("alu0", 0, 7, 4);
    drv(1, ADD, LW, 0, 0, 0, 0);
    step(ex("t6a", 0, 0, N, N, 0, N, N, 0, N, N));
    step(ex("t6b", 0, 0, N, N, 0, N, N, 0, N, N));
    drv(1, ADD, LW, 1, 0, 0, 0);
    step(ex("t6c", 0, 0, N, N, 0, N, N, 0, N, N));
    drv(1, ADD, LW, 0, 0, 0, 0);
    step(ex("t6d", 1, 2'b01, ADD, N, 2'b01, LW, N, 0, N, N));
    crd("t6", 0, 6, 4);
    drv(1, LW, ADD, 0, 0, 0, 0);
    step(ex("half", 0, 0, N, N, 2'b01, LW, N, 0, N, N));
    rst = 1'b1;
    step(ex("rst_half", 0, 0, N, N, 0, N, N, 0, N, N));
    rst = 1'b0;
    drv(0, N, N, 0, 0, 0, 0);
    crd("rst_half", 8, 8, 4);
    step(ex("post_rst", 1, 0, N, N, 0, N, N, 0, N, N));
    drv(1, ADD, LW, 0, 0, 0, 0);
    step(ex("post_pair", 1, 2'b01, ADD, N, 2'b01, LW, N, 0, N, N));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule

// File: doc/dispatch_sched.md
Name: dispatch_sched

Overview:
- Scheduler between rename and the three issue queues: ALU, MEM and MDU.
- Each cycle it receives the two-wide in-order instruction pair and steers each instruction to its queue.
- Tracks free slots per queue with credit counters.
- Dispatches in order, including partial dispatch: inst0 may go while inst1 is held.
- Backpressures upstream until the whole pair has left.

Parameters:
ALU_DEPTH, 8, ALU issue queue entries (initial ALU credits)
MEM_DEPTH, 8, MEM issue queue entries
MDU_DEPTH, 4, MDU issue queue entries

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush; drops held instruction, reloads credits
in_val  in  1  pair valid from rename
in_rdy  out  1  pair fully dispatched this cycle; upstream may advance
in_inst0  in  decoded_inst_t  older instruction
in_inst1  in  decoded_inst_t  younger instruction
alu_enq_val  out  2  ALU enqueue strobes; slot0 is older
alu_enq_inst  out  2 x decoded_inst_t  ALU enqueue payloads
alu_free  in  2  ALU entries freed this cycle (0..2)
mem_enq_val / mem_enq_inst / mem_free  same shape, MEM queue
mdu_enq_val / mdu_enq_inst / mdu_free  same shape, MDU queue

Behaviour:
- Routing per instruction:
  - is_load or is_store -> MEM.
  - else is_muldiv -> MDU.
  - else -> ALU (arith, lui/auipc, branch, jump, csr).
- Instructions with is_valid=0 are bubbles: they need no credit, produce no enqueue, and count as dispatched.
- Credits:
  - Registered, width $clog2(DEPTH+1), reset/flush value = DEPTH.
  - Next value = cur - enq_count + free.
  - Dispatch decisions use only the registered value; frees raise credits next cycle, with no same-cycle bypass.
  - Assertion: credit never exceeds DEPTH and never underflows.
- Per-queue need: the number of not-yet-dispatched valid pending instructions routed to that queue (0..2).
- In-order rule:
  - inst1 dispatches only if inst0 dispatches this cycle or was already dispatched.
  - If both target the same queue, that queue needs 2 credits for both to go; with exactly 1, only the older goes.
- Slot packing: within a queue, the oldest dispatched instruction goes in slot0. A lone dispatch always uses slot0; slot1 is valid only when slot0 is valid.
- State machine:
  - PAIR (reset): both pending.
    - Both dispatch (or are bubbles): in_rdy=1, stay PAIR.
    - Only inst0 dispatches: in_rdy=0, go to HALF.
    - Neither dispatches: in_rdy=0, stay PAIR.
  - HALF: inst0 already dispatched, inst0 ignored.
    - inst1 dispatches: in_rdy=1, go to PAIR.
    - Otherwise stay HALF.
- in_rdy is combinational. Upstream holds in_inst0/1 stable while in_val=1 and in_rdy=0; an assertion checks this.
- in_val=0: no enqueues, in_rdy=1, state unchanged. in_val=0 while in HALF is a protocol error (assert).
- Latency: zero cycles, enqueue in the same cycle as acceptance. No internal payload storage; the held instruction remains on the input.
- flush:
  - Forces state PAIR, all credits to DEPTH, all enq_val=0, in_rdy=0 that cycle.
  - Free inputs in the flush cycle are ignored, because the queues flush simultaneously.
- rst:
  - Same as flush; takes precedence over everything.
  - While rst=1: in_rdy=0 and all enq_val=0.
  - Reset mid-HALF discards the held instruction.

Decomposition:
- In uarch_pkg:
  - decoded_inst_t (existing).
  - New enum iq_sel_e {IQ_ALU, IQ_MEM, IQ_MDU}.
  - Localparam NUM_IQ=3.
  - Function iq_route(decoded_inst_t) -> iq_sel_e, reused by rename stats.
- Sub-module iq_credit_ctr (parameter DEPTH; inputs enq_cnt[1:0], free[1:0], reload; output credits), instantiated three times.
- The FSM and slot packing live in dispatch_sched.

Test Plan:
1. Reset, then pair {ADD, LW} valid -> same cycle alu_enq_val=01, mem_enq_val=01, in_rdy=1; next cycle ALU credits=7, MEM credits=7.
2. Pair {MUL, MUL}, MDU credits=1 -> cycle0: mdu_enq_val=01 (inst0), in_rdy=0, state HALF. Assert mdu_free=1 in cycle0 -> cycle1: credits=1, inst1 enqueued in slot0, in_rdy=1.
3. Pair {SW, SW}, MEM credits=0 -> no enqueue, in_rdy=0, stays PAIR. Then mem_free=2 -> next cycle both enqueue, mem_enq_val=11, credits=0.
4. Pair {inst0 is_valid=0, BEQ} -> alu_enq_val=01 carrying BEQ in slot0, in_rdy=1, ALU credits 8->7.
5. In HALF with {LW held}, assert flush -> enq_val=0, in_rdy=0; next cycle state PAIR, all credits = DEPTH (8/8/4) despite mem_free=1 in the flush cycle.
6. ALU credits=0 for 3 cycles, pair {ADD, LW} -> nothing dispatches, including LW (in-order rule). Release with alu_free=1 -> the cycle after, both dispatch, in_rdy=1.
